// File: rtl/seed_sweep_ctrl.sv
// Sweep sequencer: per seed from seed RAM, reset the SROr datapath, optionally load an
// inhibitor, start it, run to limit/steady/watchdog and stream the final state out.
module seed_sweep_ctrl #(
    parameter int RULES     = 16,
    parameter int LOG_RULES = 4,
    parameter int LOG_ITER  = 8,
    parameter int LOG_SEEDS = 8,
    parameter int SEED_W    = 64,
    parameter int WDOG_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic                 abort,
    input  logic [LOG_SEEDS:0]   num_seeds_cfg,
    input  logic [LOG_ITER-1:0]  iter_limit,
    input  logic                 early_stop_en,
    input  logic                 inhib_en,
    input  logic [LOG_RULES-1:0] inhib_sel,
    output logic [LOG_SEEDS-1:0] seed_addr,
    input  logic [SEED_W-1:0]    seed_rdata,
    output logic                 dp_rst_n,
    output logic                 dp_ld_inhibitor,
    output logic [LOG_RULES-1:0] dp_sel_inhibitor,
    output logic                 dp_start,
    output logic [SEED_W-1:0]    dp_seed,
    input  logic [LOG_ITER-1:0]  dp_iteration_number,
    input  logic                 dp_steady_state,
    input  logic [RULES-1:0]     dp_network_state,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [RULES-1:0]     res_state,
    output logic [LOG_SEEDS-1:0] res_seed_idx,
    output logic [LOG_ITER-1:0]  res_iters,
    output logic [1:0]           res_flags,
    output logic                 busy,
    output logic                 done
);

    localparam logic [LOG_SEEDS:0] NUM_SEEDS = {1'b1, {LOG_SEEDS{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_DPRST, S_LOAD, S_START, S_RUN, S_REPORT
    } state_t;

    state_t               r_state;
    logic [LOG_SEEDS:0]   r_cfg;
    logic [LOG_ITER-1:0]  r_limit;
    logic                 r_es;
    logic                 r_ie;
    logic [LOG_RULES-1:0] r_sel;
    logic [LOG_SEEDS-1:0] r_idx;
    logic                 r_rst_cnt;
    logic [WDOG_W-1:0]    r_wdog;

    logic [LOG_SEEDS-1:0] r_seed_addr;
    logic                 r_dp_rst_n;
    logic                 r_ld;
    logic [LOG_RULES-1:0] r_dp_sel;
    logic                 r_start;
    logic [SEED_W-1:0]    r_dp_seed;
    logic                 r_res_valid;
    logic [RULES-1:0]     r_res_state;
    logic [LOG_SEEDS-1:0] r_res_idx;
    logic [LOG_ITER-1:0]  r_res_iters;
    logic [1:0]           r_res_flags;
    logic                 r_busy;
    logic                 r_done;

    logic [LOG_SEEDS:0]   w_cfg_clamped;
    logic [LOG_SEEDS:0]   w_idx_nxt;
    logic                 w_more;
    logic [WDOG_W-1:0]    w_wdog_nxt;
    logic                 w_timeout;
    logic                 w_limit_hit;
    logic                 w_steady_stop;
    logic                 w_run_exit;

    assign w_cfg_clamped = (num_seeds_cfg > NUM_SEEDS) ? NUM_SEEDS : num_seeds_cfg;
    // Index compare done one bit wider so the last index of a full RAM never wraps.
    assign w_idx_nxt     = {1'b0, r_idx} + (LOG_SEEDS+1)'(1);
    assign w_more        = (w_idx_nxt < r_cfg);

    // Watchdog fires on the cycle its count would reach all-ones: 2**WDOG_W-1 RUN cycles max.
    assign w_wdog_nxt    = r_wdog + WDOG_W'(1);
    assign w_timeout     = &w_wdog_nxt;
    assign w_limit_hit   = (dp_iteration_number >= r_limit);
    assign w_steady_stop = r_es & dp_steady_state;
    assign w_run_exit    = w_limit_hit | w_steady_stop | w_timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cfg       <= '0;
            r_limit     <= '0;
            r_es        <= 1'b0;
            r_ie        <= 1'b0;
            r_sel       <= '0;
            r_idx       <= '0;
            r_rst_cnt   <= 1'b0;
            r_wdog      <= '0;
            r_seed_addr <= '0;
            r_dp_rst_n  <= 1'b0;
            r_ld        <= 1'b0;
            r_dp_sel    <= '0;
            r_start     <= 1'b0;
            r_dp_seed   <= '0;
            r_res_valid <= 1'b0;
            r_res_state <= '0;
            r_res_idx   <= '0;
            r_res_iters <= '0;
            r_res_flags <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (abort) begin
            // Abort beats everything, including a handshake in the same cycle.
            r_state     <= S_IDLE;
            r_dp_rst_n  <= 1'b0;
            r_ld        <= 1'b0;
            r_start     <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_dp_rst_n <= 1'b0;
                    if (go) begin
                        r_cfg       <= w_cfg_clamped;
                        r_limit     <= iter_limit;
                        r_es        <= early_stop_en;
                        r_ie        <= inhib_en;
                        r_sel       <= inhib_sel;
                        r_idx       <= '0;
                        r_seed_addr <= '0;
                        if (w_cfg_clamped == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: r_state <= S_LATCH;
                S_LATCH: begin
                    r_dp_seed  <= seed_rdata;
                    r_dp_rst_n <= 1'b0;
                    r_rst_cnt  <= 1'b0;
                    r_state    <= S_DPRST;
                end
                S_DPRST: begin
                    r_rst_cnt <= 1'b1;
                    if (r_rst_cnt) begin
                        r_dp_rst_n <= 1'b1;
                        if (r_ie) begin
                            r_ld     <= 1'b1;
                            r_dp_sel <= r_sel;
                            r_state  <= S_LOAD;
                        end else begin
                            r_start <= 1'b1;
                            r_state <= S_START;
                        end
                    end
                end
                S_LOAD: begin
                    r_ld    <= 1'b0;
                    r_start <= 1'b1;
                    r_state <= S_START;
                end
                S_START: begin
                    r_start <= 1'b0;
                    r_wdog  <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    r_wdog <= w_wdog_nxt;
                    if (w_run_exit) begin
                        r_res_state <= dp_network_state;
                        r_res_idx   <= r_idx;
                        r_res_iters <= dp_iteration_number;
                        r_res_flags <= {w_timeout, dp_steady_state};
                        r_res_valid <= 1'b1;
                        r_state     <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        if (w_more) begin
                            r_idx       <= w_idx_nxt[LOG_SEEDS-1:0];
                            r_seed_addr <= w_idx_nxt[LOG_SEEDS-1:0];
                            r_state     <= S_FETCH;
                        end else begin
                            r_done     <= 1'b1;
                            r_busy     <= 1'b0;
                            r_dp_rst_n <= 1'b0;
                            r_state    <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign seed_addr        = r_seed_addr;
    assign dp_rst_n         = r_dp_rst_n;
    assign dp_ld_inhibitor  = r_ld;
    assign dp_sel_inhibitor = r_dp_sel;
    assign dp_start         = r_start;
    assign dp_seed          = r_dp_seed;
    assign res_valid        = r_res_valid;
    assign res_state        = r_res_state;
    assign res_seed_idx     = r_res_idx;
    assign res_iters        = r_res_iters;
    assign res_flags        = r_res_flags;
    assign busy             = r_busy;
    assign done             = r_done;

endmodule

// File: tb/tb_seed_sweep_ctrl.sv
// Bench for seed_sweep_ctrl: seed RAM + datapath models, result scoreboard against an
// exit-cycle model computed from the limit / steady / watchdog rules.
module tb_seed_sweep_ctrl;

    localparam int RULES = 16, LOG_RULES = 4, LOG_ITER = 8, LOG_SEEDS = 8;
    localparam int SEED_W = 64, WDOG_W = 6;
    localparam int NS = 1 << LOG_SEEDS;
    localparam int WD = (1 << WDOG_W) - 1;
    localparam int NEVER = 1000;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 go = 1'b0, abort = 1'b0;
    logic [LOG_SEEDS:0]   num_seeds_cfg = '0;
    logic [LOG_ITER-1:0]  iter_limit = '0;
    logic                 early_stop_en = 1'b0, inhib_en = 1'b0;
    logic [LOG_RULES-1:0] inhib_sel = '0;
    logic [LOG_SEEDS-1:0] seed_addr;
    logic [SEED_W-1:0]    seed_rdata;
    logic                 dp_rst_n, dp_ld_inhibitor, dp_start;
    logic [LOG_RULES-1:0] dp_sel_inhibitor;
    logic [SEED_W-1:0]    dp_seed;
    logic [LOG_ITER-1:0]  dp_iteration_number;
    logic                 dp_steady_state;
    logic [RULES-1:0]     dp_network_state;
    logic                 res_valid, res_ready = 1'b1;
    logic [RULES-1:0]     res_state;
    logic [LOG_SEEDS-1:0] res_seed_idx;
    logic [LOG_ITER-1:0]  res_iters;
    logic [1:0]           res_flags;
    logic                 busy, done;

    always #5 clk = ~clk;

    seed_sweep_ctrl #(
        .RULES(RULES), .LOG_RULES(LOG_RULES), .LOG_ITER(LOG_ITER),
        .LOG_SEEDS(LOG_SEEDS), .SEED_W(SEED_W), .WDOG_W(WDOG_W)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .abort(abort),
        .num_seeds_cfg(num_seeds_cfg), .iter_limit(iter_limit),
        .early_stop_en(early_stop_en), .inhib_en(inhib_en), .inhib_sel(inhib_sel),
        .seed_addr(seed_addr), .seed_rdata(seed_rdata),
        .dp_rst_n(dp_rst_n), .dp_ld_inhibitor(dp_ld_inhibitor),
        .dp_sel_inhibitor(dp_sel_inhibitor), .dp_start(dp_start), .dp_seed(dp_seed),
        .dp_iteration_number(dp_iteration_number), .dp_steady_state(dp_steady_state),
        .dp_network_state(dp_network_state),
        .res_valid(res_valid), .res_ready(res_ready), .res_state(res_state),
        .res_seed_idx(res_seed_idx), .res_iters(res_iters), .res_flags(res_flags),
        .busy(busy), .done(done)
    );

    // Environment: synchronous seed RAM and a datapath that counts one iteration per cycle
    // after start, reporting steady once its count reaches the per-seed threshold.
    logic [63:0] ram [NS];
    int          steady_tab [NS];
    bit          stuck = 1'b0;
    logic        running;

    always @(posedge clk) seed_rdata <= ram[seed_addr];

    always @(posedge clk) begin
        if (!dp_rst_n) begin
            dp_iteration_number <= '0;
            running             <= 1'b0;
        end else if (dp_start) begin
            running <= 1'b1;
        end else if (running && !stuck && dp_iteration_number != 8'hFF) begin
            dp_iteration_number <= dp_iteration_number + 8'd1;
        end
    end

    assign dp_steady_state  = (int'(dp_iteration_number) >= steady_tab[seed_addr]);
    assign dp_network_state = dp_seed[15:0] ^ {dp_iteration_number, dp_iteration_number};

    typedef struct packed {
        logic [15:0] st;
        logic [7:0]  idx;
        logic [7:0]  it;
        logic [1:0]  fl;
    } res_t;

    res_t resq[$];
    int   runq[$];
    int   lowq[$];
    int   n_done, n_ld, n_start, n_seedbad, n_selbad, low_len, run_cnt;
    bit   in_run;
    logic [3:0] exp_sel;

    task automatic clear_mon();
        resq.delete(); runq.delete(); lowq.delete();
        n_done = 0; n_ld = 0; n_start = 0; n_seedbad = 0; n_selbad = 0;
        in_run = 1'b0; run_cnt = 0;
    endtask

    initial begin
        low_len = 0;
        clear_mon();
        forever begin
            @(negedge clk);
            if (res_valid && res_ready && !abort)
                resq.push_back({res_state, res_seed_idx, res_iters, res_flags});
            if (done) n_done++;
            if (dp_ld_inhibitor) begin
                n_ld++;
                if (dp_sel_inhibitor !== exp_sel) n_selbad++;
            end
            if (dp_start) begin
                n_start++;
                if (dp_seed !== ram[seed_addr]) n_seedbad++;
                in_run  = 1'b1;
                run_cnt = 0;
            end else if (in_run) begin
                if (res_valid) begin
                    runq.push_back(run_cnt);
                    in_run = 1'b0;
                end else begin
                    run_cnt++;
                end
            end
            if (!dp_rst_n) low_len++;
            else if (low_len > 0) begin
                lowq.push_back(low_len);
                low_len = 0;
            end
        end
    end

    int n_cmp = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected result for seed k: RUN cycle c holds iteration c-1 (0 if stuck); the run
    // ends at the earliest of limit, enabled steady state, or the watchdog cycle WD.
    function automatic res_t model(input int k, input int lim, input bit es, output int c);
        int         it;
        logic [7:0] i8;
        logic [7:0] k8;
        res_t       r;
        c = lim + 1;
        if (es && steady_tab[k] + 1 < c) c = steady_tab[k] + 1;
        if (WD < c) c = WD;
        it   = stuck ? 0 : c - 1;
        i8   = it[7:0];
        k8   = k[7:0];
        r.st = ram[k][15:0] ^ {i8, i8};
        r.idx = k8;
        r.it  = i8;
        r.fl  = {c == WD, it >= steady_tab[k]};
        return r;
    endfunction

    task automatic sweep(input string tag, input int cfg, input int lim, input bit es,
                         input bit ie, input int sel, input int rdy, input bit poke);
        int   n, cyc, c, mode, bad;
        res_t e, h;
        clear_mon();
        exp_sel = sel[3:0];
        @(posedge clk); #1;
        num_seeds_cfg = cfg[LOG_SEEDS:0];
        iter_limit    = lim[7:0];
        early_stop_en = es;
        inhib_en      = ie;
        inhib_sel     = sel[3:0];
        res_ready     = (rdy == 0);
        go            = 1'b1;
        @(posedge clk); #1;
        go            = 1'b0;
        num_seeds_cfg = 9'($urandom);
        iter_limit    = 8'($urandom);
        early_stop_en = ~es;
        inhib_en      = ~ie;
        inhib_sel     = 4'($urandom);
        n = (cfg > NS) ? NS : cfg;
        if (n == 0) begin
            chk($sformatf("%s/done_next_cycle", tag), 64'(done), 64'(1));
            chk($sformatf("%s/not_busy", tag), 64'(busy), 64'(0));
            repeat (5) @(posedge clk);
            #1;
            chk($sformatf("%s/done_count", tag), 64'(n_done), 64'(1));
            chk($sformatf("%s/no_results", tag), 64'(resq.size()), 64'(0));
            return;
        end
        mode = rdy;
        cyc  = 0;
        while (n_done == 0 && cyc < 40000) begin
            if (mode == 2 && res_valid) begin
                h = {res_state, res_seed_idx, res_iters, res_flags};
                bad = 0;
                res_ready = 1'b0;
                repeat (20) begin
                    @(posedge clk); #1;
                    cyc++;
                    if (res_valid !== 1'b1 || seed_addr !== '0 ||
                        {res_state, res_seed_idx, res_iters, res_flags} !== h) bad++;
                end
                chk($sformatf("%s/stall_hold", tag), 64'(bad), 64'(0));
                chk($sformatf("%s/stall_undelivered", tag), 64'(resq.size()), 64'(0));
                mode = 0;
            end
            go = poke && cyc == 25 && busy;
            res_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : (mode == 0);
            @(posedge clk); #1;
            cyc++;
        end
        go = 1'b0;
        res_ready = 1'b1;
        chk($sformatf("%s/done_seen", tag), 64'(n_done), 64'(1));
        repeat (3) @(posedge clk);
        #1;
        chk($sformatf("%s/done_once", tag), 64'(n_done), 64'(1));
        chk($sformatf("%s/idle_after", tag), 64'({busy, dp_rst_n, res_valid}), 64'(0));
        chk($sformatf("%s/n_results", tag), 64'(resq.size()), 64'(n));
        for (int k = 0; k < n && k < resq.size(); k++) begin
            e = model(k, lim, es, c);
            chk($sformatf("%s/res[%0d]", tag, k), 64'(resq[k]), 64'(e));
            if (k < runq.size())
                chk($sformatf("%s/run_cycles[%0d]", tag, k), 64'(runq[k]), 64'(c));
        end
        chk($sformatf("%s/ld_pulses", tag), 64'(n_ld), 64'(ie ? n : 0));
        chk($sformatf("%s/start_pulses", tag), 64'(n_start), 64'(n));
        chk($sformatf("%s/seed_to_dp", tag), 64'(n_seedbad), 64'(0));
        chk($sformatf("%s/sel_to_dp", tag), 64'(n_selbad), 64'(0));
        bad = (lowq.size() == n) ? 0 : 1;
        for (int k = 0; k < lowq.size(); k++)
            if ((k == 0) ? (lowq[k] < 2) : (lowq[k] != 2)) bad++;
        chk($sformatf("%s/dp_rst_pulses", tag), 64'(bad), 64'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        for (int i = 0; i < NS; i++) begin
            ram[i]        = {$urandom, $urandom};
            steady_tab[i] = NEVER;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset/ctrl_outputs", 64'({seed_addr, dp_rst_n, dp_ld_inhibitor, dp_sel_inhibitor,
            dp_start, res_valid, res_state, res_seed_idx, res_iters, res_flags, busy, done}), 64'(0));
        chk("reset/dp_seed", dp_seed, 64'(0));
        rst = 1'b1;

        sweep("basic", 3, 10, 1'b0, 1'b1, 5, 0, 1'b1);

        steady_tab[0] = 4; steady_tab[1] = 4;
        sweep("early_stop", 2, 50, 1'b1, 1'b0, 0, 0, 1'b0);
        sweep("no_early_stop", 2, 50, 1'b0, 1'b1, 9, 0, 1'b0);
        steady_tab[0] = NEVER; steady_tab[1] = NEVER;

        sweep("backpressure", 2, 12, 1'b0, 1'b1, 3, 2, 1'b0);
        sweep("cfg_zero", 0, 10, 1'b0, 1'b1, 0, 0, 1'b0);
        sweep("limit_zero", 2, 0, 1'b1, 1'b1, 6, 0, 1'b0);

        steady_tab[0] = 7;
        sweep("limit_and_steady", 1, 7, 1'b1, 1'b0, 0, 0, 1'b0);
        steady_tab[0] = NEVER;

        stuck = 1'b1;
        sweep("wdog_stuck", 1, 200, 1'b0, 1'b0, 0, 0, 1'b0);
        stuck = 1'b0;
        sweep("wdog_long", 2, 70, 1'b0, 1'b1, 2, 1, 1'b0);

        for (int i = 0; i < NS; i++)
            steady_tab[i] = ($urandom_range(0, 2) == 0) ? NEVER : int'($urandom_range(1, 30));
        sweep("cfg_clamp", 300, int'($urandom_range(0, 20)), 1'b1, 1'($urandom), 
              int'($urandom_range(0, 15)), 1, 1'b0);

        // abort during RUN of seed 1
        clear_mon();
        @(posedge clk); #1;
        num_seeds_cfg = 9'd3; iter_limit = 8'd20; early_stop_en = 1'b0;
        inhib_en = 1'b1; res_ready = 1'b1; go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        cyc = 0;
        while (!(dp_start && seed_addr == 8'd1) && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("abort/reached_seed1_start", 64'(cyc < 2000), 64'(1));
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort/idle_next_cycle", 64'({busy, dp_rst_n, res_valid, dp_start}), 64'(0));
        repeat (10) @(posedge clk);
        #1;
        chk("abort/no_done", 64'(n_done), 64'(0));
        chk("abort/one_result", 64'(resq.size()), 64'(1));

        // abort in the same cycle as the handshake: result dropped
        clear_mon();
        num_seeds_cfg = 9'd1; iter_limit = 8'd5; res_ready = 1'b0; go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        cyc = 0;
        while (!res_valid && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("abort_ready/valid_seen", 64'(res_valid), 64'(1));
        res_ready = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_ready/valid_dropped", 64'({res_valid, busy}), 64'(0));
        repeat (5) @(posedge clk);
        #1;
        chk("abort_ready/not_delivered", 64'(resq.size()), 64'(0));
        chk("abort_ready/no_done", 64'(n_done), 64'(0));

        sweep("restart_after_abort", 2, 8, 1'b1, 1'b0, 0, 0, 1'b0);

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 8; i++)
                steady_tab[i] = ($urandom_range(0, 1) == 0) ? NEVER : int'($urandom_range(1, 60));
            sweep($sformatf("random%0d", t), int'($urandom_range(1, 6)), int'($urandom_range(0, 70)),
                  1'($urandom), 1'($urandom), int'($urandom_range(0, 15)), 1, 1'b1);
        end

        // reset mid-sweep
        clear_mon();
        @(posedge clk); #1;
        num_seeds_cfg = 9'd5; iter_limit = 8'd30; res_ready = 1'b1; go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midreset/ctrl_outputs", 64'({seed_addr, dp_rst_n, dp_ld_inhibitor, dp_sel_inhibitor,
            dp_start, res_valid, res_state, res_seed_idx, res_iters, res_flags, busy, done}), 64'(0));
        chk("midreset/dp_seed", dp_seed, 64'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("midreset/stays_idle", 64'({busy, n_done}), 64'(0));

        sweep("after_reset", 1, 3, 1'b0, 1'b1, 1, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
